// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_responder data-memory block.
package dmem_pkg;

  localparam int          DATA_W          = 16;
  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

  // CLEAR zero-fills the array after reset; RUN serves the CPU until the next reset.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } dmem_state_e;

  // True when every address bit at or above addr_w is zero.
  // The 32-bit widening keeps this legal when addr_w == 16.
  function automatic logic addr_in_range(input logic [15:0] addr, input int addr_w);
    return ((32'(addr) >> addr_w) == 32'd0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 16 storage: one synchronous write port, one asynchronous read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Write port: commits on the rising edge when enabled.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port is combinational, so a read after a same-address write sees new data.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder on the CPU bus (DA, DD, RW).
// Optional build macro DMEM_STATS_EN adds saturating read/write counters RCNT/WCNT.
//
// Bus semantics: RW=1 is a read -- this block drives DD combinationally from DA
// and the CPU samples it at the rising edge of CK. RW=0 is a write -- DD is
// released and the CPU's value commits at the rising edge. Accesses are only
// honoured while READY=1; the CPU is expected to be held in reset while READY=0.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          ADDR_W  = 7,
  parameter logic [15:0] IO_ADDR = IO_ADDR_DEFAULT
) (
  input  logic        CK,
  input  logic        RST,
  input  logic [15:0] DA,
  inout  wire  [15:0] DD,
  input  logic        RW,
  output logic        READY,
  output logic [15:0] PORT_OUT
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0] RCNT,
  output logic [15:0] WCNT
`endif
);

  localparam int DEPTH = 2**ADDR_W;

  dmem_state_e       state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              ready_q;
  logic [15:0]       port_q;

  logic              is_io;
  logic              in_range;
  logic              cpu_wr;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [15:0]       arr_wdata;
  logic [15:0]       arr_rdata;
  logic [15:0]       rd_data;

  assign is_io    = (DA == IO_ADDR);
  assign in_range = addr_in_range(DA, ADDR_W);
  assign cpu_wr   = ready_q & ~RW & ~RST;

  // Write-port mux: the clear counter owns the array in CLEAR, the CPU in RUN.
  // The IO register wins over the array decode when the two overlap.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = '0;
    arr_wdata = '0;
    if ((state_q == CLEAR) && !RST) begin
      arr_we    = 1'b1;
      arr_waddr = clr_cnt_q;
    end else if ((state_q == RUN) && cpu_wr && !is_io && in_range) begin
      arr_we    = 1'b1;
      arr_waddr = DA[ADDR_W-1:0];
      arr_wdata = DD;
    end
  end

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk_i   (CK),
    .we_i    (arr_we),
    .waddr_i (arr_waddr),
    .wdata_i (arr_wdata),
    .raddr_i (DA[ADDR_W-1:0]),
    .rdata_o (arr_rdata)
  );

  // Clear/run FSM with registered READY and the memory-mapped output register.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
      port_q    <= 16'h0000;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          if (cpu_wr && is_io) begin
            port_q <= DD;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  // Read data: zero until the clear finishes, then IO register, array, or zero.
  always_comb begin
    rd_data = 16'h0000;
    if (!ready_q) begin
      rd_data = 16'h0000;
    end else if (is_io) begin
      rd_data = port_q;
    end else if (in_range) begin
      rd_data = arr_rdata;
    end
  end

  // Drive the bus only on a definite read; an unknown RW leaves the bus floating
  // in simulation (synthesis treats the case-equality as a plain compare).
  assign DD = (RW === 1'b1) ? rd_data : 16'hzzzz;

  assign READY    = ready_q;
  assign PORT_OUT = port_q;

`ifdef DMEM_STATS_EN
  logic [15:0] rcnt_q;
  logic [15:0] wcnt_q;

  // Saturating access counters; every RUN cycle is either a read or a write.
  always_ff @(posedge CK) begin
    if (RST) begin
      rcnt_q <= 16'h0000;
      wcnt_q <= 16'h0000;
    end else if (state_q == RUN) begin
      if (RW) begin
        if (rcnt_q != 16'hFFFF) rcnt_q <= rcnt_q + 16'h0001;
      end else begin
        if (wcnt_q != 16'hFFFF) wcnt_q <= wcnt_q + 16'h0001;
      end
    end
  end

  assign RCNT = rcnt_q;
  assign WCNT = wcnt_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: behavioural model plus literal checks.
module tb_dmem_responder;

  // ---------------- clock / reset / bus ----------------
  logic        ck = 1'b0;
  logic        rst = 1'b1;
  logic        rw = 1'b1;
  logic [15:0] da = 16'h0000;
  logic [15:0] dd_drv = 16'h0000;
  wire  [15:0] dd;
  logic        ready;
  logic [15:0] port_out;
`ifdef DMEM_STATS_EN
  logic [15:0] rcnt;
  logic [15:0] wcnt;
`endif

  always #5 ck = ~ck;

  assign dd = rw ? 16'hzzzz : dd_drv;

  dmem_responder dut (
    .CK       (ck),
    .RST      (rst),
    .DA       (da),
    .DD       (dd),
    .RW       (rw),
    .READY    (ready),
    .PORT_OUT (port_out)
`ifdef DMEM_STATS_EN
    ,
    .RCNT     (rcnt),
    .WCNT     (wcnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Memory image becomes all-zero at the moment READY rises; before that reads are 0.
  logic [15:0] m_mem [128];
  logic [15:0] m_port;
  bit          m_ready;
  bit          m_valid = 0;
  int          m_left;
  int          m_rc, m_wc;

  function automatic logic [15:0] exp_rd(input logic [15:0] a);
    if (!m_ready) return 16'h0000;
    if (a == 16'hFFFF) return m_port;
    if (a < 16'd128) return m_mem[a[6:0]];
    return 16'h0000;
  endfunction

  always @(posedge ck) begin
    if (rst) begin
      m_valid = 1;
      m_ready = 0;
      m_left  = 128;
      m_port  = 16'h0000;
      m_rc    = 0;
      m_wc    = 0;
    end else if (m_valid && !m_ready) begin
      m_left--;
      if (m_left == 0) begin
        m_ready = 1;
        foreach (m_mem[i]) m_mem[i] = 16'h0000;
      end
    end else if (m_valid) begin
      if (rw) begin
        if (m_rc < 65535) m_rc++;
      end else begin
        if (m_wc < 65535) m_wc++;
        if (da == 16'hFFFF) m_port = dd_drv;
        else if (da < 16'd128) m_mem[da[6:0]] = dd_drv;
      end
    end
  end

  // Compare process: every negedge once the model has seen a reset.
  always @(negedge ck) begin
    if (m_valid) begin
      check("ready", {15'd0, ready}, {15'd0, m_ready});
      check("port_out", port_out, m_port);
      if (rw) check("read_data", dd, exp_rd(da));
      else    check("write_bus", dd, dd_drv);
`ifdef DMEM_STATS_EN
      check("rcnt", rcnt, 16'(m_rc));
      check("wcnt", wcnt, 16'(m_wc));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs are applied at posedge+1 and held across the next rising edge.
  task automatic cyc(input logic r, input logic [15:0] a, input logic [15:0] d);
    rw = r; da = a; dd_drv = d;
    @(posedge ck); #1;
  endtask

  task automatic rd_chk(input logic [15:0] a, input logic [15:0] exp);
    rw = 1'b1; da = a;
    #1;
    check("read_literal", dd, exp);
    @(posedge ck); #1;
  endtask

  function automatic logic [15:0] rand_addr();
    int sel = $urandom_range(0, 9);
    if (sel < 7) return 16'($urandom_range(0, 127));
    if (sel == 7) return 16'hFFFF;
    return 16'($urandom);
  endfunction

  // Count cycles until READY rises, reading random addresses meanwhile.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 300) begin
      cyc(1'b1, rand_addr(), 16'h0000);
      n++;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) cyc(1'b1, rand_addr(), 16'h0000);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [15:0] a;

    // Reset and clear
    do_reset(5);
    check("ready_after_reset", {15'd0, ready}, 16'h0000);
    check("port_after_reset", port_out, 16'h0000);
    wait_ready(n);
    check("clear_len", 16'(n), 16'd128);
    for (int i = 0; i < 128; i++) rd_chk(16'(i), 16'h0000);

    // Write then read
    cyc(1'b0, 16'h0000, 16'h0003);
    cyc(1'b0, 16'h0001, 16'h0004);
    rd_chk(16'h0000, 16'h0003);
    rd_chk(16'h0001, 16'h0004);

    // Output register leaves mem[127] alone
    cyc(1'b0, 16'd127, 16'h5A5A);
    cyc(1'b0, 16'hFFFF, 16'h00A5);
    check("port_literal", port_out, 16'h00A5);
    rd_chk(16'hFFFF, 16'h00A5);
    rd_chk(16'd127, 16'h5A5A);

    // Out of range write is ignored
    cyc(1'b0, 16'h0080, 16'h1234);
    rd_chk(16'h0080, 16'h0000);
    rd_chk(16'h0000, 16'h0003);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      a = rand_addr();
      cyc(1'($urandom_range(0, 1)), a, 16'($urandom));
    end

    // Reset in RUN after writing mem[5]=7
    cyc(1'b0, 16'd5, 16'h0007);
    rd_chk(16'd5, 16'h0007);
    cyc(1'b0, 16'hFFFF, 16'h00A5);
    do_reset(2);
    wait_ready(n);
    check("reclear_len", 16'(n), 16'd128);
    rd_chk(16'd5, 16'h0000);
    check("port_after_reclear", port_out, 16'h0000);

    // Reset mid-clear at count 60
    do_reset(1);
    repeat (60) cyc(1'b1, rand_addr(), 16'h0000);
    do_reset(1);
    wait_ready(n);
    check("midclear_restart_len", 16'(n), 16'd128);

`ifdef DMEM_STATS_EN
    // Three reads and two writes right after READY
    cyc(1'b1, 16'd1, 16'h0000);
    cyc(1'b1, 16'hFFFF, 16'h0000);
    cyc(1'b1, 16'h0200, 16'h0000);
    cyc(1'b0, 16'd2, 16'h0009);
    cyc(1'b0, 16'h0300, 16'h0009);
    check("rcnt_literal", rcnt, 16'd3);
    check("wcnt_literal", wcnt, 16'd2);

    // Saturation
    do_reset(1);
    wait_ready(n);
    repeat (65534) cyc(1'b1, rand_addr(), 16'h0000);
    check("rcnt_fffe", rcnt, 16'hFFFE);
    repeat (3) cyc(1'b1, rand_addr(), 16'h0000);
    check("rcnt_sat", rcnt, 16'hFFFF);
    check("wcnt_zero", wcnt, 16'h0000);
`endif

    // Final report
    @(negedge ck);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
